ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite responder: on-chip word-organised SRAM on one slave port of BusController.
//  Decodes address phase; optional wait states; byte/halfword/word writes.
//  Two-cycle ERROR for illegal transfers.
//  Drives one per-device rdata/ready/resp slot; receives the shared master-side signals.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte address of word 0
//  DEPTH_WORDS  512            32-bit words stored; 2048 bytes, equal to slot-0 map size
//  WAIT_STATES  0              ready_out low cycles inserted before each OKAY completion
// PORTS
//  clock      in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  sel        in   1   slave select from BusController decode
//  addr       in   32  byte address (address phase)
//  write      in   1   1=write, 0=read (address phase)
//  size       in   3   transfer_size: 0=byte, 1=half, 2=word, >2 illegal
//  trans      in   2   transfer_kind: 0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
//  ready_in   in   1   bus-wide HREADY (previous transfer done)
//  wdata      in   32  write data (data phase)
//  rdata      out  32  read data, valid when ready_out=1 and resp=OKAY
//  ready_out  out  1   slave ready for this slot
//  resp       out  1   transfer_response: 0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset: ready_out=1, resp=OKAY, rdata=0, state=IDLE, no pending phase.
//   Reset mid-transfer: pending write is discarded. SRAM contents are not reset.
//  Accept: address phase is taken on an edge where sel & ready_in & trans[1].
//   Latch addr, write, size; classify legality.
//   sel & ready_in & trans in {IDLE,BUSY}: no transfer; next cycle ready_out=1, OKAY.
//  Illegal: size>2; addr misaligned to size; (addr-BASE_ADDR) >= DEPTH_WORDS*4.
//   Out-of-range test is unsigned, so addr < BASE_ADDR is also out of range.
//  States: IDLE, WAIT, ERR1, ERR2.
//   IDLE: ready_out=1, resp=OKAY.
//   Legal accept, WAIT_STATES=0: stay IDLE; next cycle is the completion cycle.
//   Legal accept, WAIT_STATES>0: go to WAIT with wait counter=WAIT_STATES.
//   Illegal accept: go to ERR1.
//   WAIT: ready_out=0, resp=OKAY; counter decrements each cycle.
//   WAIT, counter==1: go to IDLE; next cycle is the completion cycle.
//   ERR1: ready_out=0, resp=ERROR; always go to ERR2.
//   ERR2: ready_out=1, resp=ERROR. A new accept here is handled as from IDLE.
//  Completion cycle: ready_out=1, resp=OKAY.
//   Read: rdata = full 32-bit word at latched index; all lanes driven.
//   Write: wdata committed at the closing edge, with byte enables.
//   Byte enables: size0 lane addr[1:0]; size1 lanes {addr[1],0}+1:0; size2 all lanes.
//   Lanes are little-endian: lane n = wdata[8n+7:8n].
//  Read latency: rdata valid exactly 1+WAIT_STATES cycles after the accept edge.
//  Illegal transfers never write SRAM; rdata holds its previous value.
//  Pipelining: a new address phase may be accepted on the completion edge (back-to-back).
//  Hazard: read accept coinciding with a same-word write completion returns merged data.
//   Written lanes come from wdata; other lanes from SRAM. No extra stall.
//  Index = (addr-BASE_ADDR)>>2, width $clog2(DEPTH_WORDS); index never wraps.
//  sel deasserted during WAIT/ERR does not abort; the data phase finishes.
// TESTING
//  1. Reset held 3 cycles, then released -> ready_out=1, resp=0, rdata=0.
//  2. Word write 32'hDEADBEEF @BASE+0x10, then read @0x10, WAIT_STATES=0:
//     -> rdata=32'hDEADBEEF on cycle after read accept; ready_out never low.
//  3. Byte write 8'hAA @0x13 over word 32'h11223344, then word read @0x10:
//     -> 32'hAA223344. Halfword write 16'h5566 @0x12 -> 32'h55663344.
//  4. Back-to-back: write 32'h0000_00FF @0x20, read @0x20 accepted on write completion edge:
//     -> rdata=32'h0000_00FF (forwarding); repeat with WAIT_STATES=2 -> same data, 2 ready_out-low cycles.
//  5. Illegal transfers: read @0x801 size1 (misaligned); read @BASE+2048 (range); size=3:
//     -> each gives ready_out 0 then 1, resp=ERROR both cycles; no SRAM change.
//  6. WAIT_STATES=3, reset asserted during WAIT of a write 32'h12345678 @0x40:
//     -> IDLE outputs next cycle; later read @0x40 returns the old value.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder fronting a word-organised on-chip SRAM.
// Accepts address phases from the bus, inserts optional wait states, performs
// byte/halfword/word writes with lane enables, and answers illegal transfers
// with the two-cycle ERROR response. Reads complete with the full 32-bit word.
module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 512,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [2:0]  size,
    input  logic [1:0]  trans,
    input  logic        ready_in,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready_out,
    output logic        resp
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam int          CNT_W       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam bit          ZERO_WAIT   = (WAIT_STATES == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             pend_valid;
    logic             pend_write;
    logic [IDX_W-1:0] pend_idx;
    logic [3:0]       pend_be;
    logic [31:0]      mem [DEPTH_WORDS];

    logic [31:0]      offset;
    logic             accept, legal, align_ok;
    logic [IDX_W-1:0] acc_idx, rd_idx;
    logic [3:0]       acc_be;
    logic             complete, commit, rd_load;
    logic [31:0]      merged;
    logic             unused_trans;

    // trans[0] only distinguishes IDLE/BUSY and NONSEQ/SEQ, neither of which matters here
    assign unused_trans = trans[0];

    // Offset is unsigned, so addresses below BASE_ADDR wrap high and fail the range test
    assign offset   = addr - BASE_ADDR;
    assign acc_idx  = offset[IDX_W+1:2];
    assign accept   = sel & ready_in & trans[1] & ((state == S_IDLE) | (state == S_ERR2));
    assign legal    = (size <= 3'd2) & align_ok & ({1'b0, offset} < RANGE_BYTES);
    assign complete = (state == S_IDLE) & pend_valid;
    assign commit   = complete & pend_write;

    // Alignment and byte-lane enables for the incoming address phase
    always_comb begin
        align_ok = 1'b0;
        acc_be   = 4'b0000;
        case (size)
            3'd0: begin
                align_ok = 1'b1;
                acc_be   = 4'b0001 << addr[1:0];
            end
            3'd1: begin
                align_ok = ~addr[0];
                acc_be   = addr[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                align_ok = (addr[1:0] == 2'b00);
                acc_be   = 4'b1111;
            end
            default: ;
        endcase
    end

    // Choose when read data is captured so it is valid exactly 1+WAIT_STATES cycles after accept
    always_comb begin
        if (ZERO_WAIT) begin
            rd_load = accept & legal & ~write;
            rd_idx  = acc_idx;
        end else begin
            rd_load = (state == S_WAIT) & (wait_cnt == CNT_W'(1)) & ~pend_write;
            rd_idx  = pend_idx;
        end
    end

    // Forward lanes of a same-word write that commits on the edge the read is captured
    always_comb begin
        merged = mem[rd_idx];
        for (int n = 0; n < 4; n++) begin
            if (commit && (pend_idx == rd_idx) && pend_be[n]) begin
                merged[8*n +: 8] = wdata[8*n +: 8];
            end
        end
    end

    // FSM next state and the per-state ready/response outputs
    always_comb begin
        state_next = state;
        ready_out  = 1'b1;
        resp       = 1'b0;
        case (state)
            S_IDLE, S_ERR2: begin
                resp       = (state == S_ERR2);
                state_next = S_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_next = S_ERR1;
                    end else if (!ZERO_WAIT) begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                ready_out = 1'b0;
                if (wait_cnt == CNT_W'(1)) begin
                    state_next = S_IDLE;
                end
            end
            S_ERR1: begin
                ready_out  = 1'b0;
                resp       = 1'b1;
                state_next = S_ERR2;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register, pending data-phase bookkeeping and read data register
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_write <= 1'b0;
            pend_idx   <= '0;
            pend_be    <= '0;
            rdata      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pend_valid <= legal;
                pend_write <= write;
                pend_idx   <= acc_idx;
                pend_be    <= acc_be;
                wait_cnt   <= CNT_W'(WAIT_STATES);
            end else if (complete) begin
                pend_valid <= 1'b0;
            end
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (rd_load) begin
                rdata <= merged;
            end
        end
    end

    // Commit write data with lane enables at the closing edge of the completion cycle
    // NOTE: the storage array has no reset branch; clearing it would force flops instead of SRAM.
    always_ff @(posedge clock) begin
        if (!reset && commit) begin
            for (int n = 0; n < 4; n++) begin
                if (pend_be[n]) begin
                    mem[pend_idx][8*n +: 8] <= wdata[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed stimulus for three slave instances (0, 2 and 3 wait
// states) sharing the master-side signals. Expected responses are queued when each
// address phase is issued; a monitor pops and compares on every completion cycle.
module tb_ahb_sram_slave;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          waits;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel [3];
    logic [31:0] addr, wdata;
    logic        write;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic        ro [3];
    logic        rs [3];
    logic [31:0] rd [3];

    exp_t exp_q [3][$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   dphase  [3];
    int   lowcnt  [3];
    bit   low_or  [3];
    bit   low_and [3];

    always #5 clk = ~clk;

    // index 0: zero wait states, index 1: two, index 2: three
    ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .clock(clk), .reset(reset), .sel(sel[0]), .addr(addr), .write(write), .size(size),
        .trans(trans), .ready_in(ro[0]), .wdata(wdata), .rdata(rd[0]), .ready_out(ro[0]), .resp(rs[0]));
    ahb_sram_slave #(.WAIT_STATES(2)) u_dut2 (
        .clock(clk), .reset(reset), .sel(sel[1]), .addr(addr), .write(write), .size(size),
        .trans(trans), .ready_in(ro[1]), .wdata(wdata), .rdata(rd[1]), .ready_out(ro[1]), .resp(rs[1]));
    ahb_sram_slave #(.WAIT_STATES(3)) u_dut3 (
        .clock(clk), .reset(reset), .sel(sel[2]), .addr(addr), .write(write), .size(size),
        .trans(trans), .ready_in(ro[2]), .wdata(wdata), .rdata(rd[2]), .ready_out(ro[2]), .resp(rs[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    // Monitor: score each completion cycle against the oldest queued expectation
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                dphase[i]  = 1'b0;
                lowcnt[i]  = 0;
                low_or[i]  = 1'b0;
                low_and[i] = 1'b1;
                exp_q[i].delete();
            end else begin
                if (dphase[i] && ro[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected completion dut%0d", i), 32'd1, 32'd0);
                    end else begin
                        mon_e = exp_q[i].pop_front();
                        check({mon_e.name, " resp"}, 32'(rs[i]), 32'(mon_e.err));
                        check({mon_e.name, " low cycles"}, lowcnt[i], mon_e.waits);
                        check({mon_e.name, " low resp"}, 32'(mon_e.err ? low_and[i] : low_or[i]),
                              32'(mon_e.err));
                        if (mon_e.chk) check({mon_e.name, " rdata"}, rd[i], mon_e.data);
                    end
                    lowcnt[i]  = 0;
                    low_or[i]  = 1'b0;
                    low_and[i] = 1'b1;
                end else if (dphase[i]) begin
                    lowcnt[i]++;
                    low_or[i]  = low_or[i] | rs[i];
                    low_and[i] = low_and[i] & rs[i];
                end
                if (ro[i]) dphase[i] = sel[i] && trans[1];
            end
        end
    end

    task automatic expect_rsp(input int i, input string n, input logic err, input logic chk,
                              input logic [31:0] d, input int w);
        exp_t e;
        e.err = err; e.chk = chk; e.data = d; e.waits = w; e.name = n;
        exp_q[i].push_back(e);
    endtask

    task automatic go_idle();
        for (int k = 0; k < 3; k++) sel[k] = 1'b0;
        trans = 2'd0;
    endtask

    task automatic addr_phase(input int i, input logic [31:0] a, input logic w, input logic [2:0] sz);
        bit done = 1'b0;
        for (int k = 0; k < 3; k++) sel[k] = (k == i);
        addr = a; write = w; size = sz; trans = 2'd2;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (ro[i]) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check($sformatf("accept timeout dut%0d", i), 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int i);
        bit done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (ro[i]) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check($sformatf("completion timeout dut%0d", i), 32'd0, 32'd1);
    endtask

    task automatic do_write(input int i, input string n, input logic [31:0] a,
                            input logic [2:0] sz, input logic [31:0] d);
        expect_rsp(i, n, 1'b0, 1'b0, 32'd0, ws_of(i));
        addr_phase(i, a, 1'b1, sz);
        wdata = d;
        go_idle();
        wait_done(i);
    endtask

    task automatic do_read(input int i, input string n, input logic [31:0] a, input logic [31:0] exp);
        expect_rsp(i, n, 1'b0, 1'b1, exp, ws_of(i));
        addr_phase(i, a, 1'b0, 3'd2);
        go_idle();
        wait_done(i);
    endtask

    task automatic do_err(input int i, input string n, input logic [31:0] a, input logic w,
                          input logic [2:0] sz, input logic [31:0] prev);
        expect_rsp(i, n, 1'b1, 1'b1, prev, 1);
        addr_phase(i, a, w, sz);
        wdata = 32'h0000_0000;
        go_idle();
        wait_done(i);
    endtask

    // write then a word read accepted on the write's completion edge
    task automatic do_wr_rd(input int i, input string n, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] d, input logic [31:0] ra, input logic [31:0] exp);
        expect_rsp(i, {n, " wr"}, 1'b0, 1'b0, 32'd0, ws_of(i));
        expect_rsp(i, {n, " rd"}, 1'b0, 1'b1, exp, ws_of(i));
        addr_phase(i, a, 1'b1, sz);
        wdata = d;
        addr_phase(i, ra, 1'b0, 3'd2);
        go_idle();
        wait_done(i);
    endtask

    // Global watchdog so the run always ends
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        reset = 1'b1;
        addr  = '0; wdata = '0; write = 1'b0; size = 3'd2;
        go_idle();

        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset ready_out dut%0d", i), 32'(ro[i]), 32'd1);
            check($sformatf("reset resp dut%0d", i), 32'(rs[i]), 32'd0);
            check($sformatf("reset rdata dut%0d", i), rd[i], 32'd0);
        end
        @(posedge clk); #1;

        // Word write and read back, zero wait states
        do_write(0, "t2 wr", 32'h10, 3'd2, 32'hDEAD_BEEF);
        do_read (0, "t2 rd", 32'h10, 32'hDEAD_BEEF);

        // Byte and halfword writes: unused lanes carry junk that must not land
        do_write(0, "t3 word", 32'h10, 3'd2, 32'h1122_3344);
        do_write(0, "t3 byte", 32'h13, 3'd0, 32'hAA99_8877);
        do_read (0, "t3 rd byte", 32'h10, 32'hAA22_3344);
        do_write(0, "t3 half", 32'h12, 3'd1, 32'h5566_9988);
        do_read (0, "t3 rd half", 32'h10, 32'h5566_3344);

        // Back-to-back read on the write completion edge, full word and partial merge
        do_wr_rd(0, "t4 word", 32'h20, 3'd2, 32'h0000_00FF, 32'h20, 32'h0000_00FF);
        do_wr_rd(0, "t4 merge", 32'h21, 3'd0, 32'h1111_AB22, 32'h20, 32'h0000_ABFF);
        do_wr_rd(1, "t4 ws2", 32'h20, 3'd2, 32'h0000_00FF, 32'h20, 32'h0000_00FF);

        // Illegal transfers: rdata holds the previous read value, SRAM untouched
        do_err(0, "t5 misalign half", 32'h801, 1'b0, 3'd1, 32'h0000_ABFF);
        do_err(0, "t5 misalign word", 32'h11,  1'b0, 3'd2, 32'h0000_ABFF);
        do_err(0, "t5 range",         32'h800, 1'b0, 3'd2, 32'h0000_ABFF);
        do_err(0, "t5 size3 rd",      32'h10,  1'b0, 3'd3, 32'h0000_ABFF);
        do_err(0, "t5 size3 wr",      32'h10,  1'b1, 3'd3, 32'h0000_ABFF);
        do_err(0, "t5 misalign wr",   32'h12,  1'b1, 3'd2, 32'h0000_ABFF);
        do_read(0, "t5 intact", 32'h10, 32'h5566_3344);

        // Selected BUSY is not a transfer: the slot stays ready and OKAY
        sel[0] = 1'b1; trans = 2'd1; addr = 32'h10; write = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("busy ready_out", 32'(ro[0]), 32'd1);
            check("busy resp", 32'(rs[0]), 32'd0);
        end
        @(posedge clk); #1;
        go_idle();

        // Reset during the wait states of a write discards it
        do_write(2, "t6 pre", 32'h40, 3'd2, 32'hCAFE_F00D);
        expect_rsp(2, "t6 discarded", 1'b0, 1'b0, 32'd0, 3);
        addr_phase(2, 32'h40, 1'b1, 3'd2);
        wdata = 32'h1234_5678;
        go_idle();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6 ready_out after reset", 32'(ro[2]), 32'd1);
        check("t6 resp after reset", 32'(rs[2]), 32'd0);
        check("t6 rdata after reset", rd[2], 32'd0);
        @(posedge clk); #1;
        do_read(2, "t6 old value", 32'h40, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("scoreboard drained dut%0d", i), exp_q[i].size(), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
